stack_ctrl: RTL and testbench

Two-requester controller for a `stack_reg` hardware stack. It arbitrates push/pop requests from two clients, for example the core and an interrupt or debug engine, using round-robin. It drives the stack's `load`/`read` strobes and `data_in`, and returns the top-of-stack word on pops. It tracks occupancy, refuses overflow and underflow, and exposes status and sticky error flags.

---
 rtl/stack_ctrl.sv | 148 ++++++++++++++
 tb/tb_stack_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// Round-robin two-client push/pop controller for a stack_reg hardware stack.
// Optional high-water mark output is compiled in with `define STACK_CTRL_WATERMARK_EN.
module stack_ctrl #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          sysclk,
  input  logic          sysreset_n,
  input  logic [15:0]   stk_data_out,
  output logic [15:0]   stk_data_in,
  output logic          stk_load,
  output logic          stk_read,
  input  logic          a_req,
  input  logic          a_op,
  input  logic [15:0]   a_wdata,
  output logic          a_ack,
  output logic [15:0]   a_rdata,
  output logic          a_err,
  input  logic          b_req,
  input  logic          b_op,
  input  logic [15:0]   b_wdata,
  output logic          b_ack,
  output logic [15:0]   b_rdata,
  output logic          b_err,
  input  logic          flush,
  input  logic          clr_err,
  output logic [CW-1:0] depth_count,
  output logic          empty,
  output logic          full,
`ifdef STACK_CTRL_WATERMARK_EN
  output logic [CW-1:0] hiwater,
`endif
  output logic          overflow,
  output logic          underflow
);

  typedef enum logic {IDLE, SERVE} state_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t        state_q, state_d;
  logic          win_b_q, win_b_d;
  logic          last_b_q, last_b_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          op_q, op_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          serve, push_ok, push_bad, pop_ok, pop_bad, grant_b;

  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign depth_count = count_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

  // A flush during SERVE kills the operation before any strobe or ack escapes.
  always_comb begin
    serve       = (state_q == SERVE) && !flush;
    push_ok     = serve &&  op_q && !full;
    push_bad    = serve &&  op_q &&  full;
    pop_ok      = serve && !op_q && !empty;
    pop_bad     = serve && !op_q &&  empty;
    stk_load    = push_ok;
    stk_read    = pop_ok;
    stk_data_in = push_ok ? wdata_q : 16'h0000;
    a_ack       = serve && !win_b_q;
    b_ack       = serve &&  win_b_q;
    a_err       = a_ack && (push_bad || pop_bad);
    b_err       = b_ack && (push_bad || pop_bad);
    a_rdata     = (a_ack && pop_ok) ? stk_data_out : 16'h0000;
    b_rdata     = (b_ack && pop_ok) ? stk_data_out : 16'h0000;
  end

  always_comb begin
    state_d  = state_q;
    win_b_d  = win_b_q;
    last_b_d = last_b_q;
    count_d  = count_q;
    op_d     = op_q;
    wdata_d  = wdata_q;
    grant_b  = b_req && (!a_req || !last_b_q);
    if (flush) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (a_req || b_req) begin
            win_b_d  = grant_b;
            last_b_d = grant_b;
            op_d     = grant_b ? b_op : a_op;
            wdata_d  = grant_b ? b_wdata : a_wdata;
            state_d  = SERVE;
          end
        end
        default: begin
          state_d = IDLE;
          if (push_ok) count_d = count_q + CW'(1);
          if (pop_ok)  count_d = count_q - CW'(1);
        end
      endcase
    end
    // A fresh error in the clearing cycle keeps its flag set.
    ovf_d = (ovf_q && !clr_err) || push_bad;
    unf_d = (unf_q && !clr_err) || pop_bad;
  end

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state_q  <= IDLE;
      win_b_q  <= 1'b0;
      last_b_q <= 1'b1;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_b_q  <= win_b_d;
      last_b_q <= last_b_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge sysclk) begin
    op_q    <= op_d;
    wdata_q <= wdata_d;
  end

`ifdef STACK_CTRL_WATERMARK_EN
  logic [CW-1:0] hiwater_q, hiwater_d;

  always_comb begin
    hiwater_d = (count_q > hiwater_q) ? count_q : hiwater_q;
    if (clr_err) hiwater_d = count_q;
  end

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) hiwater_q <= '0;
    else             hiwater_q <= hiwater_d;
  end

  assign hiwater = hiwater_q;
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl: directed client operations against a behavioural stack_reg.
module tb_stack_ctrl;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          sysclk, sysreset_n;
  logic [15:0]   stk_data_out, stk_data_in;
  logic          stk_load, stk_read;
  logic          a_req, a_op, a_ack, a_err;
  logic [15:0]   a_wdata, a_rdata;
  logic          b_req, b_op, b_ack, b_err;
  logic [15:0]   b_wdata, b_rdata;
  logic          flush, clr_err;
  logic [CW-1:0] depth_count;
  logic          empty, full, overflow, underflow;
`ifdef STACK_CTRL_WATERMARK_EN
  logic [CW-1:0] hiwater;
`endif

  stack_ctrl #(.DEPTH(DEPTH)) dut (
    .sysclk(sysclk), .sysreset_n(sysreset_n),
    .stk_data_out(stk_data_out), .stk_data_in(stk_data_in),
    .stk_load(stk_load), .stk_read(stk_read),
    .a_req(a_req), .a_op(a_op), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_op(b_op), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .flush(flush), .clr_err(clr_err),
    .depth_count(depth_count), .empty(empty), .full(full),
`ifdef STACK_CTRL_WATERMARK_EN
    .hiwater(hiwater),
`endif
    .overflow(overflow), .underflow(underflow)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Behavioural stack_reg.
  logic [15:0] mem [0:DEPTH-1];
  int sp;
  always @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) sp <= 0;
    else if (stk_load && sp < DEPTH) begin
      mem[sp] <= stk_data_in;
      sp <= sp + 1;
    end else if (stk_read && sp > 0) sp <= sp - 1;
  end
  assign stk_data_out = (sp > 0) ? mem[sp-1] : 16'h0000;

  typedef struct {
    logic        is_b;
    logic        err;
    logic [15:0] rdata;
    logic        load;
    logic        read;
    logic [15:0] din;
  } exp_t;
  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every ack consumes the oldest expectation.
  always @(negedge sysclk) begin
    exp_t e;
    if (sysreset_n) begin
      if (a_ack || b_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack: got a=%0b b=%0b expected none", a_ack, b_ack);
        end else begin
          e = exp_q.pop_front();
          chk("ack_excl",   {31'b0, a_ack && b_ack}, 32'd0);
          chk("ack_client", {31'b0, b_ack}, {31'b0, e.is_b});
          chk("err",        {31'b0, (e.is_b ? b_err : a_err)}, {31'b0, e.err});
          chk("rdata",      {16'h0, (e.is_b ? b_rdata : a_rdata)}, {16'h0, e.rdata});
          chk("other_rdata",{16'h0, (e.is_b ? a_rdata : b_rdata)}, 32'd0);
          chk("stk_load",   {31'b0, stk_load}, {31'b0, e.load});
          chk("stk_read",   {31'b0, stk_read}, {31'b0, e.read});
          chk("stk_data_in",{16'h0, stk_data_in}, {16'h0, e.din});
        end
      end else if (stk_load || stk_read) begin
        checks++;
        failures++;
        $display("FAIL strobe_without_ack: got load=%0b read=%0b expected 0 0", stk_load, stk_read);
      end
    end
  end

  task automatic do_op(input bit is_b, input bit op, input logic [15:0] wd,
                       input bit exp_err, input logic [15:0] exp_rd);
    exp_t e;
    int n;
    bit got;
    e.is_b = is_b; e.err = exp_err; e.rdata = exp_rd;
    e.load = op && !exp_err; e.read = !op && !exp_err;
    e.din  = e.load ? wd : 16'h0000;
    exp_q.push_back(e);
    if (is_b) begin b_req = 1'b1; b_op = op; b_wdata = wd; end
    else      begin a_req = 1'b1; a_op = op; a_wdata = wd; end
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(posedge sysclk); #1;
      n++;
      got = is_b ? b_ack : a_ack;
    end
    chk("ack_latency", n, 32'd1);
    @(posedge sysclk); #1;
    if (is_b) b_req = 1'b0; else a_req = 1'b0;
  endtask

  task automatic do_reset();
    chk("queue_drained", exp_q.size(), 32'd0);
    exp_q.delete();
    sysreset_n = 1'b0;
    a_req = 0; a_op = 0; a_wdata = 0;
    b_req = 0; b_op = 0; b_wdata = 0;
    flush = 0; clr_err = 0;
    repeat (2) @(posedge sysclk);
    #1 sysreset_n = 1'b1;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge sysclk); #1;
    clr_err = 1'b0;
  endtask

  initial begin
    int n;
    sysreset_n = 1'b0;
    do_reset();
    chk("rst_depth",     depth_count, 32'd0);
    chk("rst_empty",     empty, 32'd1);
    chk("rst_full",      full, 32'd0);
    chk("rst_overflow",  overflow, 32'd0);
    chk("rst_underflow", underflow, 32'd0);
    chk("rst_strobes",   {stk_load, stk_read}, 32'd0);
    chk("rst_data_in",   stk_data_in, 32'd0);
    chk("rst_acks",      {a_ack, b_ack, a_err, b_err}, 32'd0);
    chk("rst_rdata",     {a_rdata, b_rdata}, 32'd0);

    do_op(0, 1, 16'h1234, 0, 16'h0000);
    chk("t1_depth", depth_count, 32'd1);
    chk("t1_empty", empty, 32'd0);

    do_reset();
    for (int i = 1; i <= 8; i++) do_op(0, 1, 16'(i), 0, 16'h0000);
    chk("fill_full", full, 32'd1);
    do_op(0, 1, 16'hBEEF, 1, 16'h0000);
    chk("ovf_flag",  overflow, 32'd1);
    chk("ovf_full",  full, 32'd1);
    chk("ovf_depth", depth_count, 32'd8);
    pulse_clr();
    chk("ovf_clear", overflow, 32'd0);
    for (int i = 0; i < 8; i++) do_op(1, 0, 16'h0000, 0, 16'(8 - i));
    chk("drain_empty", empty, 32'd1);
    do_op(1, 0, 16'h0000, 1, 16'h0000);
    chk("unf_flag",  underflow, 32'd1);
    chk("unf_empty", empty, 32'd1);
    chk("unf_depth", depth_count, 32'd0);

    do_reset();
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{is_b: (i % 2 == 1), err: 1'b0, rdata: 16'h0000, load: 1'b1,
                        read: 1'b0, din: (i % 2 == 1) ? 16'hBBBB : 16'hAAAA});
    a_req = 1; a_op = 1; a_wdata = 16'hAAAA;
    b_req = 1; b_op = 1; b_wdata = 16'hBBBB;
    repeat (8) @(posedge sysclk);
    #1 a_req = 0; b_req = 0;
    chk("rr_depth", depth_count, 32'd4);
    chk("rr_queue", exp_q.size(), 32'd0);

    do_reset();
    do_op(0, 1, 16'h0011, 0, 16'h0000);
    do_op(0, 1, 16'h0022, 0, 16'h0000);
    chk("fl_pre_depth", depth_count, 32'd2);
    exp_q.push_back('{is_b: 1'b1, err: 1'b1, rdata: 16'h0000, load: 1'b0, read: 1'b0, din: 16'h0000});
    b_req = 1; b_op = 0;
    @(posedge sysclk); #1;
    flush = 1'b1;
    #1;
    chk("fl_no_ack",  {a_ack, b_ack}, 32'd0);
    chk("fl_no_read", stk_read, 32'd0);
    @(posedge sysclk); #1;
    flush = 1'b0;
    chk("fl_depth", depth_count, 32'd0);
    n = 0;
    while (!b_ack && n < 20) begin @(posedge sysclk); #1; n++; end
    chk("fl_regrant", n, 32'd1);
    @(posedge sysclk); #1;
    b_req = 0;
    chk("fl_underflow", underflow, 32'd1);
    chk("fl_empty", empty, 32'd1);

`ifdef STACK_CTRL_WATERMARK_EN
    do_reset();
    for (int i = 1; i <= 5; i++) do_op(0, 1, 16'(16'h0100 + i), 0, 16'h0000);
    for (int i = 0; i < 3; i++)  do_op(1, 0, 16'h0000, 0, 16'(16'h0105 - i));
    @(posedge sysclk); #1;
    chk("hw_peak", hiwater, 32'd5);
    pulse_clr();
    chk("hw_clear", hiwater, 32'd2);
`endif

    n = 0;
    while (exp_q.size() != 0 && n < 10) begin @(posedge sysclk); #1; n++; end
    chk("final_queue", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
